// File: rtl/ofifo_drain_ctrl_if.sv
// ofifo_drain_ctrl_if: groups the job-control, ofifo and psum SRAM signals of
// the ofifo drain sequencer. The slave modport is the sequencer; the master
// modport is whatever drives jobs, feeds the FIFO side and watches the SRAM side.
interface ofifo_drain_ctrl_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8
);
  logic                     start;
  logic [addr_bw-1:0]       base_addr;
  logic [cnt_bw-1:0]        num_rows;
  logic                     fifo_valid;
  logic [col*psum_bw-1:0]   fifo_data;
  logic                     fifo_rd;
  logic                     sram_stall;
  logic                     sram_cen;
  logic                     sram_wen;
  logic [addr_bw-1:0]       sram_addr;
  logic [col*psum_bw-1:0]   sram_d;
  logic                     busy;
  logic                     done;
  logic                     ovf;

  modport master (
    output start, base_addr, num_rows, fifo_valid, fifo_data, sram_stall,
    input  fifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done, ovf
  );

  modport slave (
    input  start, base_addr, num_rows, fifo_valid, fifo_data, sram_stall,
    output fifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done, ovf
  );
endinterface

// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl: drains completed psum rows from the output FIFO into the
// psum SRAM. Occupancy is tracked from the FIFO's row-valid strobe, pops are
// issued only when a row is present and the SRAM port is free, and each popped
// row is written one cycle later to base + index (modulo 2^addr_bw).
// Optional feature macro: OFIFO_DRAIN_RELU_EN clamps negative lanes to zero
// on their way to the SRAM without changing write latency.
module ofifo_drain_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8,
  parameter int depth   = 128
) (
  input logic               clk,
  input logic               reset,
  ofifo_drain_ctrl_if.slave bus
);

  localparam int RW = col * psum_bw;
  localparam logic [cnt_bw-1:0] DEPTH_C = cnt_bw'(depth);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

`ifdef OFIFO_DRAIN_RELU_EN
  // Clamp every signed lane that is negative to zero; others pass through.
  function automatic logic [RW-1:0] relu_row(input logic [RW-1:0] row);
    logic [RW-1:0] res;
    res = row;
    for (int i = 0; i < col; i++) begin
      if (row[i*psum_bw + psum_bw - 1]) begin
        res[i*psum_bw +: psum_bw] = {psum_bw{1'b0}};
      end else begin
        res[i*psum_bw +: psum_bw] = row[i*psum_bw +: psum_bw];
      end
    end
    return res;
  endfunction
`endif

  state_t              state_r, state_s;
  logic                pop_s, load_s;
  logic [cnt_bw-1:0]   occ_r, occ_s;
  logic                ovf_r, ovf_set_s;
  // issued_r doubles as the write index: the row popped now is the
  // issued_r-th row of the job and lands at base_r + issued_r.
  logic [cnt_bw-1:0]   issued_r;
  logic [cnt_bw-1:0]   num_r;
  logic [addr_bw-1:0]  base_r;
  logic [RW-1:0]       wr_data_s;
  logic                cen_r, wen_r;
  logic [addr_bw-1:0]  addr_r;
  logic [RW-1:0]       d_r;
  logic                busy_r, done_r;

  // FSM next state, pop decision and job-parameter load strobe.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          load_s = 1'b1;
          if (bus.num_rows == {cnt_bw{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        pop_s = (occ_r != {cnt_bw{1'b0}}) && !bus.sram_stall && (issued_r < num_r);
        if (pop_s && ((issued_r + cnt_bw'(1)) == num_r)) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FLUSH: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Occupancy bookkeeping; a push into a full FIFO without a pop is lost.
  always_comb begin
    occ_s     = occ_r;
    ovf_set_s = 1'b0;
    if (bus.fifo_valid && !pop_s) begin
      if (occ_r == DEPTH_C) begin
        ovf_set_s = 1'b1;
      end else begin
        occ_s = occ_r + cnt_bw'(1);
      end
    end else if (!bus.fifo_valid && pop_s) begin
      occ_s = occ_r - cnt_bw'(1);
    end else begin
      occ_s = occ_r;
    end
  end

  // Data headed for the SRAM, optionally ReLU-clipped.
  always_comb begin
`ifdef OFIFO_DRAIN_RELU_EN
    wr_data_s = relu_row(bus.fifo_data);
`else
    wr_data_s = bus.fifo_data;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Occupancy counter and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_r <= {cnt_bw{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      occ_r <= occ_s;
      ovf_r <= ovf_r | ovf_set_s;
    end
  end

  // Job parameters latched on an accepted start; issued row counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_r   <= {addr_bw{1'b0}};
      num_r    <= {cnt_bw{1'b0}};
      issued_r <= {cnt_bw{1'b0}};
    end else if (load_s) begin
      base_r   <= bus.base_addr;
      num_r    <= bus.num_rows;
      issued_r <= {cnt_bw{1'b0}};
    end else if (pop_s) begin
      issued_r <= issued_r + cnt_bw'(1);
    end
  end

  // Write stage: a pop this cycle becomes an SRAM write next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cen_r  <= 1'b1;
      wen_r  <= 1'b1;
      addr_r <= {addr_bw{1'b0}};
      d_r    <= {RW{1'b0}};
    end else if (pop_s) begin
      cen_r  <= 1'b0;
      wen_r  <= 1'b0;
      addr_r <= base_r + addr_bw'(issued_r);
      d_r    <= wr_data_s;
    end else begin
      cen_r  <= 1'b1;
      wen_r  <= 1'b1;
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_DRAIN) || (state_s == ST_FLUSH);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign bus.fifo_rd   = pop_s;
  assign bus.sram_cen  = cen_r;
  assign bus.sram_wen  = wen_r;
  assign bus.sram_addr = addr_r;
  assign bus.sram_d    = d_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// tb_ofifo_drain_ctrl: directed stimulus for ofifo_drain_ctrl with a write
// scoreboard. Expected SRAM writes are queued when a job is launched; a
// monitor compares every write the DUT presents.
module tb_ofifo_drain_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [127:0] push_data = 128'd0;
  logic [127:0] rowq[$];
  logic [10:0]  exp_addr_q[$];
  logic [127:0] exp_data_q[$];
  logic         prev_rd = 1'b0;

  localparam logic [127:0] ROW_NEG = 128'hFFF0_0123_FFF0_0123_FFF0_0123_FFF0_0123;
`ifdef OFIFO_DRAIN_RELU_EN
  localparam logic [127:0] EXP_NEG = 128'h0000_0123_0000_0123_0000_0123_0000_0123;
`else
  localparam logic [127:0] EXP_NEG = 128'hFFF0_0123_FFF0_0123_FFF0_0123_FFF0_0123;
`endif

  ofifo_drain_ctrl_if #(.col(8), .psum_bw(16), .addr_bw(11), .cnt_bw(8)) bus ();

  ofifo_drain_ctrl #(.col(8), .psum_bw(16), .addr_bw(11), .cnt_bw(8), .depth(128)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_row(input logic [15:0] v);
    return {8{v}};
  endfunction

  // Show-ahead FIFO model feeding the DUT.
  always @(posedge clk) begin
    if (rst) begin
      rowq.delete();
    end else begin
      if (bus.fifo_rd && rowq.size() > 0) void'(rowq.pop_front());
      if (bus.fifo_valid) rowq.push_back(push_data);
    end
    bus.fifo_data <= (rowq.size() > 0) ? rowq[0] : 128'd0;
  end

  // Scoreboard monitor: every SRAM write must match the next expectation.
  always @(negedge clk) begin
    if (!rst && bus.sram_cen == 1'b0) begin
      check("wr_pending", 128'(exp_addr_q.size() != 0), 128'd1);
      if (exp_addr_q.size() != 0) begin
        check("wr_addr", 128'(bus.sram_addr), 128'(exp_addr_q.pop_front()));
        check("wr_data", bus.sram_d, exp_data_q.pop_front());
        check("wr_wen", 128'(bus.sram_wen), 128'd0);
        check("wr_latency", 128'(prev_rd), 128'd1);
      end
    end
    prev_rd <= rst ? 1'b0 : bus.fifo_rd;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [127:0] r);
    push_data = r;
    bus.fifo_valid = 1'b1;
    step();
    bus.fifo_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [10:0] a, input logic [127:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic start_job(input logic [10:0] base, input logic [7:0] num);
    bus.base_addr = base;
    bus.num_rows  = num;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
  endtask

  // Watch a running job cycle by cycle (cycle 1 = first cycle after start).
  task automatic watch(input string tag, input int exp_pops, input int exp_span,
                       input int exp_done, input bit exp_busy1,
                       input int stall_lo, input int stall_hi,
                       input int extra_cyc, input logic [127:0] extra_row,
                       input int occ_exp);
    int pops = 0;
    int first_pop = 0;
    int last_pop = 0;
    int done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      bus.sram_stall = (c >= stall_lo) && (c <= stall_hi);
      if (c == extra_cyc) begin
        push_data      = extra_row;
        bus.fifo_valid = 1'b1;
        bus.start      = 1'b1;
        bus.base_addr  = 11'h3FF;
        bus.num_rows   = 8'd9;
      end
      @(negedge clk);
      if (c == 1) check({tag, "_busy_c1"}, 128'(bus.busy), 128'(exp_busy1));
      if (bus.fifo_rd) begin
        pops++;
        if (first_pop == 0) first_pop = c;
        last_pop = c;
        if (bus.sram_stall) check({tag, "_pop_in_stall"}, 128'd1, 128'd0);
      end
      if (extra_cyc != 0 && c == extra_cyc + 1)
        check({tag, "_occ_simul"}, 128'(dut.occ_r), 128'(occ_exp));
      if (bus.done) begin
        done_cyc = c;
        check({tag, "_busy_at_done"}, 128'(bus.busy), 128'd0);
      end
      step();
      bus.fifo_valid = 1'b0;
      bus.start      = 1'b0;
      bus.sram_stall = 1'b0;
    end
    check({tag, "_pops"}, 128'(pops), 128'(exp_pops));
    check({tag, "_pop_span"}, 128'((pops > 0) ? (last_pop - first_pop + 1) : 0), 128'(exp_span));
    check({tag, "_done_cycle"}, 128'(done_cyc), 128'(exp_done));
    check({tag, "_occ_end"}, 128'(dut.occ_r), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.base_addr = 11'd0;
    bus.num_rows = 8'd0;
    bus.fifo_valid = 1'b0;
    bus.sram_stall = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_fifo_rd", 128'(bus.fifo_rd), 128'd0);
    check("rst_cen", 128'(bus.sram_cen), 128'd1);
    check("rst_wen", 128'(bus.sram_wen), 128'd1);
    check("rst_addr", 128'(bus.sram_addr), 128'd0);
    check("rst_d", bus.sram_d, 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_ovf", 128'(bus.ovf), 128'd0);
    check("rst_occ", 128'(dut.occ_r), 128'd0);
    step();
    rst = 1'b0;
    step();

    // Idle pushes: occupancy counts, nothing is popped or written.
    push_row(mk_row(16'h0011));
    push_row(ROW_NEG);
    push_row(mk_row(16'h0033));
    @(negedge clk);
    check("idle_occ", 128'(dut.occ_r), 128'd3);
    check("idle_fifo_rd", 128'(bus.fifo_rd), 128'd0);
    check("idle_cen", 128'(bus.sram_cen), 128'd1);
    step();

    // Back-to-back drain of 4 rows from 0x010 (includes a negative-lane row).
    push_row(mk_row(16'h0044));
    expect_wr(11'h010, mk_row(16'h0011));
    expect_wr(11'h011, EXP_NEG);
    expect_wr(11'h012, mk_row(16'h0033));
    expect_wr(11'h013, mk_row(16'h0044));
    start_job(11'h010, 8'd4);
    watch("b2b", 4, 4, 6, 1'b1, 0, -1, 0, 128'd0, 0);

    // Stall cycles 3..5: pops at 1,2,6,7, writes contiguous at 0x100.
    for (int i = 0; i < 4; i++) push_row(mk_row(16'h0055 + 16'(i)));
    for (int i = 0; i < 4; i++) expect_wr(11'h100 + 11'(i), mk_row(16'h0055 + 16'(i)));
    start_job(11'h100, 8'd4);
    watch("stall", 4, 7, 9, 1'b1, 3, 5, 0, 128'd0, 0);

    // Address wrap past 0x7FF.
    for (int i = 0; i < 4; i++) push_row(mk_row(16'h0061 + 16'(i)));
    expect_wr(11'h7FE, mk_row(16'h0061));
    expect_wr(11'h7FF, mk_row(16'h0062));
    expect_wr(11'h000, mk_row(16'h0063));
    expect_wr(11'h001, mk_row(16'h0064));
    start_job(11'h7FE, 8'd4);
    watch("wrap", 4, 4, 6, 1'b1, 0, -1, 0, 128'd0, 0);

    // Zero-row job: done the cycle after start, no SRAM access.
    start_job(11'h123, 8'd0);
    watch("empty", 0, 0, 1, 1'b0, 0, -1, 0, 128'd0, 0);

    // Simultaneous pop+push and an ignored start in cycle 2.
    push_row(mk_row(16'h0071));
    push_row(mk_row(16'h0072));
    expect_wr(11'h020, mk_row(16'h0071));
    expect_wr(11'h021, mk_row(16'h0072));
    expect_wr(11'h022, mk_row(16'h0073));
    start_job(11'h020, 8'd3);
    watch("simul", 3, 3, 5, 1'b1, 0, -1, 2, mk_row(16'h0073), 1);

    // Overflow: 128 pushes fill the FIFO, the 129th sets the sticky flag.
    for (int i = 0; i < 128; i++) push_row(mk_row(16'(i)));
    @(negedge clk);
    check("full_ovf", 128'(bus.ovf), 128'd0);
    check("full_occ", 128'(dut.occ_r), 128'd128);
    step();
    push_row(mk_row(16'h0999));
    @(negedge clk);
    check("ovf_set", 128'(bus.ovf), 128'd1);
    check("ovf_occ", 128'(dut.occ_r), 128'd128);
    check("ovf_fifo_rd", 128'(bus.fifo_rd), 128'd0);
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("ovf_cleared", 128'(bus.ovf), 128'd0);

    // Reset mid-job: only the first row's write completes before reset.
    for (int i = 0; i < 4; i++) push_row(mk_row(16'h0081 + 16'(i)));
    expect_wr(11'h200, mk_row(16'h0081));
    start_job(11'h200, 8'd4);
    @(posedge clk);
    #6;
    rst = 1'b1;
    #1;
    check("midrst_cen", 128'(bus.sram_cen), 128'd1);
    check("midrst_wen", 128'(bus.sram_wen), 128'd1);
    check("midrst_busy", 128'(bus.busy), 128'd0);
    check("midrst_fifo_rd", 128'(bus.fifo_rd), 128'd0);
    step();
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check("midrst_occ", 128'(dut.occ_r), 128'd0);
    check("midrst_idle_cen", 128'(bus.sram_cen), 128'd1);
    check("wr_all_seen", 128'(exp_addr_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
